mem_cmd_issuer: RTL and testbench

MEM_CMD_ISSUER -- requirements
Module: mem_cmd_issuer

---
 rtl/mem_cmd_issuer.sv | 176 +++++++++++++++++
 tb/tb_mem_cmd_issuer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_cmd_issuer.sv
// Avalon-MM command issuer: one registered read/write slot, outstanding-read
// credit tracking, stall timeout with sticky error, and read-data return.
module mem_cmd_issuer #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int BE_W      = DATA_W / 8,
    parameter int MAX_OUTST = 8,
    parameter int TIMEOUT   = 1023
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              trans_en_i,
    input  logic              trans_type_i,
    input  logic [ADDR_W-1:0] trans_addr_i,
    input  logic [DATA_W-1:0] trans_data_i,
    input  logic [BE_W-1:0]   trans_be_i,

    output logic              cmd_accepted_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_data_valid_o,
    input  logic              clear_i,
    output logic              busy_o,
    output logic [6:0]        outst_cnt_o,
    output logic              timeout_o,
    output logic              unexp_rd_o,

    output logic [ADDR_W-1:0] amm_address_o,
    output logic              amm_read_o,
    output logic              amm_write_o,
    output logic [DATA_W-1:0] amm_writedata_o,
    output logic [BE_W-1:0]   amm_byteenable_o,
    input  logic              amm_waitrequest_i,
    input  logic [DATA_W-1:0] amm_readdata_i,
    input  logic              amm_readdatavalid_i
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        outst_q, outst_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              tout_q, tout_d;
    logic              unexp_q, unexp_d;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    logic       acc;
    logic       rd_acc;
    logic       dec;
    logic       slot;
    logic       credit;
    logic       stall;
    logic       to_hit;
    logic [6:0] outst_nxt;

    // Credit looks at the count as it will stand after this edge
    always_comb begin
        acc       = (rd_q | wr_q) & ~amm_waitrequest_i;
        rd_acc    = rd_q & ~amm_waitrequest_i;
        dec       = amm_readdatavalid_i & (outst_q != 7'd0);
        outst_nxt = outst_q + {6'd0, rd_acc} - {6'd0, dec};
        credit    = ~trans_type_i | (outst_nxt < 7'(MAX_OUTST));
        slot      = (state_q == IDLE) | ((state_q == ISSUE) & acc);
        stall     = ((state_q == ISSUE) & amm_waitrequest_i)
                  | ((outst_q != 7'd0) & ~amm_readdatavalid_i);
        to_hit    = (tcnt_q == TW'(TIMEOUT));
        cmd_accepted_o = trans_en_i & slot & credit
                       & (state_q != ERROR) & ~clear_i & ~rst_i;
    end

    always_comb begin
        state_d = state_q;
        outst_d = outst_q;
        tcnt_d  = tcnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        tout_d  = tout_q;
        unexp_d = unexp_q;

        if (clear_i) begin
            state_d = IDLE;
            outst_d = 7'd0;
            tcnt_d  = '0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            tout_d  = 1'b0;
            unexp_d = 1'b0;
        end else begin
            outst_d = outst_nxt;
            if (amm_readdatavalid_i && outst_q == 7'd0)
                unexp_d = 1'b1;

            if (!stall)
                tcnt_d = '0;
            else if (!to_hit)
                tcnt_d = tcnt_q + 1'b1;

            // Abort wins over any issue or completion this cycle
            if (to_hit) begin
                state_d = ERROR;
                tout_d  = 1'b1;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end else if (cmd_accepted_o) begin
                state_d = ISSUE;
                addr_d  = trans_addr_i;
                wdata_d = trans_data_i;
                be_d    = trans_be_i;
                rd_d    = trans_type_i;
                wr_d    = ~trans_type_i;
            end else if (state_q == ISSUE && acc) begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            outst_q  <= 7'd0;
            tcnt_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            tout_q   <= 1'b0;
            unexp_q  <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            outst_q  <= outst_d;
            tcnt_q   <= tcnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            tout_q   <= tout_d;
            unexp_q  <= unexp_d;
            rdata_q  <= amm_readdata_i;
            rvalid_q <= amm_readdatavalid_i;
        end
    end

    assign amm_address_o    = addr_q;
    assign amm_writedata_o  = wdata_q;
    assign amm_byteenable_o = be_q;
    assign amm_read_o       = rd_q;
    assign amm_write_o      = wr_q;
    assign rd_data_o        = rdata_q;
    assign rd_data_valid_o  = rvalid_q;
    assign outst_cnt_o      = outst_q;
    assign timeout_o        = tout_q;
    assign unexp_rd_o       = unexp_q;
    assign busy_o           = (state_q == ISSUE) | (outst_q != 7'd0);

endmodule

// File: tb/tb_mem_cmd_issuer.sv
// Directed bench for mem_cmd_issuer: issue, stall, credit, return,
// timeout, unexpected data and reset behaviour.
module tb_mem_cmd_issuer;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int BE_W   = DATA_W / 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              trans_en_i;
    logic              trans_type_i;
    logic [ADDR_W-1:0] trans_addr_i;
    logic [DATA_W-1:0] trans_data_i;
    logic [BE_W-1:0]   trans_be_i;
    logic              cmd_accepted_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_data_valid_o;
    logic              clear_i;
    logic              busy_o;
    logic [6:0]        outst_cnt_o;
    logic              timeout_o;
    logic              unexp_rd_o;
    logic [ADDR_W-1:0] amm_address_o;
    logic              amm_read_o;
    logic              amm_write_o;
    logic [DATA_W-1:0] amm_writedata_o;
    logic [BE_W-1:0]   amm_byteenable_o;
    logic              amm_waitrequest_i;
    logic [DATA_W-1:0] amm_readdata_i;
    logic              amm_readdatavalid_i;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    mem_cmd_issuer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
        .MAX_OUTST(8), .TIMEOUT(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .trans_en_i(trans_en_i), .trans_type_i(trans_type_i),
        .trans_addr_i(trans_addr_i), .trans_data_i(trans_data_i),
        .trans_be_i(trans_be_i),
        .cmd_accepted_o(cmd_accepted_o), .rd_data_o(rd_data_o),
        .rd_data_valid_o(rd_data_valid_o), .clear_i(clear_i),
        .busy_o(busy_o), .outst_cnt_o(outst_cnt_o),
        .timeout_o(timeout_o), .unexp_rd_o(unexp_rd_o),
        .amm_address_o(amm_address_o), .amm_read_o(amm_read_o),
        .amm_write_o(amm_write_o), .amm_writedata_o(amm_writedata_o),
        .amm_byteenable_o(amm_byteenable_o),
        .amm_waitrequest_i(amm_waitrequest_i),
        .amm_readdata_i(amm_readdata_i),
        .amm_readdatavalid_i(amm_readdatavalid_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        trans_en_i = 1'b1;
        trans_type_i = 1'b0;
        trans_addr_i = 32'h5;
        repeat (2) @(posedge clk_i);
        #1;
        chk_cnt++; if (cmd_accepted_o !== 1'b0) $display("FAIL rst_acc: got %b want 0", cmd_accepted_o); else pass_cnt++;
        chk_cnt++; if ({amm_read_o, amm_write_o} !== 2'b00) $display("FAIL rst_rdwr: got %b want 00", {amm_read_o, amm_write_o}); else pass_cnt++;
        chk_cnt++; if (amm_address_o !== '0) $display("FAIL rst_addr: got %h want 0", amm_address_o); else pass_cnt++;
        chk_cnt++; if ({busy_o, timeout_o, unexp_rd_o, rd_data_valid_o} !== 4'b0) $display("FAIL rst_flags: got %b want 0000", {busy_o, timeout_o, unexp_rd_o, rd_data_valid_o}); else pass_cnt++;
        chk_cnt++; if (outst_cnt_o !== 7'd0) $display("FAIL rst_outst: got %0d want 0", outst_cnt_o); else pass_cnt++;
        trans_en_i = 1'b0;
        rst_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        amm_waitrequest_i = 1'b0;
        trans_en_i = 1'b1;
        trans_type_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            trans_addr_i = 32'h10 + i;
            trans_data_i = 128'h1000 + i;
            @(negedge clk_i);
            chk_cnt++; if (cmd_accepted_o !== 1'b1) $display("FAIL b2b_acc%0d: got %b want 1", i, cmd_accepted_o); else pass_cnt++;
            if (i > 0) begin
                chk_cnt++; if (amm_write_o !== 1'b1 || amm_address_o !== 32'h10 + i - 1) $display("FAIL b2b_wr%0d: got wr=%b addr=%h want 1/%h", i, amm_write_o, amm_address_o, 32'h10 + i - 1); else pass_cnt++;
            end
            tick();
        end
        trans_en_i = 1'b0;
        @(negedge clk_i);
        chk_cnt++; if (amm_write_o !== 1'b1 || amm_address_o !== 32'h12 || cmd_accepted_o !== 1'b0) $display("FAIL b2b_last: got wr=%b addr=%h acc=%b want 1/12/0", amm_write_o, amm_address_o, cmd_accepted_o); else pass_cnt++;
        tick();
        @(negedge clk_i);
        chk_cnt++; if ({amm_write_o, amm_read_o, busy_o} !== 3'b000) $display("FAIL b2b_idle: got %b want 000", {amm_write_o, amm_read_o, busy_o}); else pass_cnt++;
        tick();
    endtask

    task automatic test_waitrequest();
        int pulses;
        amm_waitrequest_i = 1'b1;
        trans_en_i = 1'b1;
        trans_type_i = 1'b0;
        trans_addr_i = 32'h20;
        trans_data_i = 128'hDEAD_BEEF;
        trans_be_i = 16'h00FF;
        @(negedge clk_i);
        pulses = cmd_accepted_o ? 1 : 0;
        tick();
        trans_en_i = 1'b0;
        trans_addr_i = 32'h0;
        trans_data_i = '0;
        trans_be_i = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            if (cmd_accepted_o) pulses++;
            chk_cnt++; if (amm_write_o !== 1'b1 || amm_address_o !== 32'h20 || amm_writedata_o !== 128'hDEAD_BEEF || amm_byteenable_o !== 16'h00FF) $display("FAIL wait_hold%0d: got wr=%b addr=%h be=%h want 1/20/00ff", k, amm_write_o, amm_address_o, amm_byteenable_o); else pass_cnt++;
            tick();
        end
        amm_waitrequest_i = 1'b0;
        @(negedge clk_i);
        if (cmd_accepted_o) pulses++;
        tick();
        chk_cnt++; if (amm_write_o !== 1'b0) $display("FAIL wait_done: got wr=%b want 0", amm_write_o); else pass_cnt++;
        chk_cnt++; if (pulses !== 1) $display("FAIL wait_pulses: got %0d want 1", pulses); else pass_cnt++;
    endtask

    task automatic test_outstanding();
        int nacc;
        nacc = 0;
        amm_waitrequest_i = 1'b0;
        trans_en_i = 1'b1;
        trans_type_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            trans_addr_i = 32'h100 + nacc;
            @(negedge clk_i);
            if (cmd_accepted_o) nacc++;
            tick();
        end
        chk_cnt++; if (nacc !== 8) $display("FAIL outst_nacc: got %0d want 8", nacc); else pass_cnt++;
        chk_cnt++; if (outst_cnt_o !== 7'd8) $display("FAIL outst_full: got %0d want 8", outst_cnt_o); else pass_cnt++;
        amm_readdatavalid_i = 1'b1;
        @(negedge clk_i);
        chk_cnt++; if (cmd_accepted_o !== 1'b1) $display("FAIL outst_ninth: got %b want 1", cmd_accepted_o); else pass_cnt++;
        tick();
        amm_readdatavalid_i = 1'b0;
        @(negedge clk_i);
        chk_cnt++; if (cmd_accepted_o !== 1'b0 || outst_cnt_o !== 7'd7) $display("FAIL outst_tenth: got acc=%b cnt=%0d want 0/7", cmd_accepted_o, outst_cnt_o); else pass_cnt++;
        tick();
        chk_cnt++; if (outst_cnt_o !== 7'd8) $display("FAIL outst_refill: got %0d want 8", outst_cnt_o); else pass_cnt++;
        trans_en_i = 1'b0;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk_cnt++; if (outst_cnt_o !== 7'd0 || busy_o !== 1'b0 || timeout_o !== 1'b0) $display("FAIL outst_clear: got cnt=%0d busy=%b to=%b want 0/0/0", outst_cnt_o, busy_o, timeout_o); else pass_cnt++;
    endtask

    task automatic test_read_return();
        amm_waitrequest_i = 1'b0;
        trans_en_i = 1'b1;
        trans_type_i = 1'b1;
        trans_addr_i = 32'h40;
        @(negedge clk_i);
        chk_cnt++; if (cmd_accepted_o !== 1'b1) $display("FAIL rd_acc: got %b want 1", cmd_accepted_o); else pass_cnt++;
        tick();
        trans_en_i = 1'b0;
        tick();
        amm_readdatavalid_i = 1'b1;
        amm_readdata_i = 128'hA5A5;
        @(negedge clk_i);
        chk_cnt++; if (rd_data_valid_o !== 1'b0) $display("FAIL rd_early: got %b want 0", rd_data_valid_o); else pass_cnt++;
        tick();
        amm_readdatavalid_i = 1'b0;
        amm_readdata_i = '0;
        chk_cnt++; if (rd_data_valid_o !== 1'b1 || rd_data_o !== 128'hA5A5) $display("FAIL rd_data: got v=%b d=%h want 1/a5a5", rd_data_valid_o, rd_data_o); else pass_cnt++;
        chk_cnt++; if (outst_cnt_o !== 7'd0 || busy_o !== 1'b0) $display("FAIL rd_drain: got cnt=%0d busy=%b want 0/0", outst_cnt_o, busy_o); else pass_cnt++;
        tick();
        chk_cnt++; if (rd_data_valid_o !== 1'b0) $display("FAIL rd_pulse: got %b want 0", rd_data_valid_o); else pass_cnt++;
    endtask

    task automatic test_timeout();
        amm_waitrequest_i = 1'b1;
        trans_en_i = 1'b1;
        trans_type_i = 1'b0;
        trans_addr_i = 32'h50;
        @(negedge clk_i);
        chk_cnt++; if (cmd_accepted_o !== 1'b1) $display("FAIL to_acc: got %b want 1", cmd_accepted_o); else pass_cnt++;
        tick();
        trans_en_i = 1'b0;
        repeat (15) tick();
        chk_cnt++; if (timeout_o !== 1'b0 || amm_write_o !== 1'b1) $display("FAIL to_early: got to=%b wr=%b want 0/1", timeout_o, amm_write_o); else pass_cnt++;
        repeat (2) tick();
        chk_cnt++; if (timeout_o !== 1'b1 || {amm_read_o, amm_write_o} !== 2'b00) $display("FAIL to_fire: got to=%b rdwr=%b want 1/00", timeout_o, {amm_read_o, amm_write_o}); else pass_cnt++;
        trans_en_i = 1'b1;
        trans_addr_i = 32'h51;
        @(negedge clk_i);
        chk_cnt++; if (cmd_accepted_o !== 1'b0) $display("FAIL to_block: got %b want 0", cmd_accepted_o); else pass_cnt++;
        tick();
        clear_i = 1'b1;
        @(negedge clk_i);
        chk_cnt++; if (cmd_accepted_o !== 1'b0) $display("FAIL to_clracc: got %b want 0", cmd_accepted_o); else pass_cnt++;
        tick();
        clear_i = 1'b0;
        amm_waitrequest_i = 1'b0;
        chk_cnt++; if (timeout_o !== 1'b0) $display("FAIL to_clear: got %b want 0", timeout_o); else pass_cnt++;
        @(negedge clk_i);
        chk_cnt++; if (cmd_accepted_o !== 1'b1) $display("FAIL to_resume: got %b want 1", cmd_accepted_o); else pass_cnt++;
        tick();
        trans_en_i = 1'b0;
        chk_cnt++; if (amm_write_o !== 1'b1 || amm_address_o !== 32'h51) $display("FAIL to_issue: got wr=%b addr=%h want 1/51", amm_write_o, amm_address_o); else pass_cnt++;
        tick();
    endtask

    task automatic test_unexpected();
        amm_readdatavalid_i = 1'b1;
        amm_readdata_i = 128'h77;
        tick();
        amm_readdatavalid_i = 1'b0;
        chk_cnt++; if (unexp_rd_o !== 1'b1 || outst_cnt_o !== 7'd0) $display("FAIL unexp_flag: got u=%b cnt=%0d want 1/0", unexp_rd_o, outst_cnt_o); else pass_cnt++;
        chk_cnt++; if (rd_data_valid_o !== 1'b1 || rd_data_o !== 128'h77) $display("FAIL unexp_fwd: got v=%b d=%h want 1/77", rd_data_valid_o, rd_data_o); else pass_cnt++;
        tick();
        chk_cnt++; if (unexp_rd_o !== 1'b1) $display("FAIL unexp_sticky: got %b want 1", unexp_rd_o); else pass_cnt++;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk_cnt++; if (unexp_rd_o !== 1'b0) $display("FAIL unexp_clear: got %b want 0", unexp_rd_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        amm_waitrequest_i = 1'b1;
        trans_en_i = 1'b1;
        trans_type_i = 1'b0;
        trans_addr_i = 32'h60;
        trans_data_i = 128'h1234;
        tick();
        chk_cnt++; if (amm_write_o !== 1'b1 || busy_o !== 1'b1) $display("FAIL rmid_pre: got wr=%b busy=%b want 1/1", amm_write_o, busy_o); else pass_cnt++;
        #1;
        rst_i = 1'b1;
        #1;
        chk_cnt++; if ({amm_write_o, amm_read_o, busy_o, cmd_accepted_o} !== 4'b0000) $display("FAIL rmid_ctl: got %b want 0000", {amm_write_o, amm_read_o, busy_o, cmd_accepted_o}); else pass_cnt++;
        chk_cnt++; if (amm_address_o !== '0 || amm_writedata_o !== '0) $display("FAIL rmid_data: got addr=%h wd=%h want 0/0", amm_address_o, amm_writedata_o); else pass_cnt++;
        tick();
        rst_i = 1'b0;
        amm_waitrequest_i = 1'b0;
        @(negedge clk_i);
        chk_cnt++; if (cmd_accepted_o !== 1'b1) $display("FAIL rmid_first: got %b want 1", cmd_accepted_o); else pass_cnt++;
        tick();
        trans_en_i = 1'b0;
        chk_cnt++; if (amm_write_o !== 1'b1 || amm_address_o !== 32'h60) $display("FAIL rmid_issue: got wr=%b addr=%h want 1/60", amm_write_o, amm_address_o); else pass_cnt++;
        tick();
    endtask

    initial begin
        trans_en_i = 1'b0;
        trans_type_i = 1'b0;
        trans_addr_i = '0;
        trans_data_i = '0;
        trans_be_i = 16'hFFFF;
        clear_i = 1'b0;
        amm_waitrequest_i = 1'b0;
        amm_readdata_i = '0;
        amm_readdatavalid_i = 1'b0;
        test_reset();
        test_back_to_back();
        test_waitrequest();
        test_outstanding();
        test_read_return();
        test_timeout();
        test_unexpected();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
